// File: rtl/tft_fetch_pkg.sv
// ============================================================================
//  Module   : tft_fetch_pkg
//  Brief    : Shared state encoding and sizing helpers for the frame fetcher.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package tft_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CLEAR      = 3'd1,
        WAIT_SPACE = 3'd2,
        REQ        = 3'd3,
        XFER       = 3'd4,
        DONE       = 3'd5
    } fetch_state_t;

    function automatic int unsigned frame_words(input int unsigned h_active,
                                                input int unsigned v_active);
        return h_active * v_active;
    endfunction

    // Minimum of one bit so a degenerate frame size still yields a legal vector.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tft_underflow_mon.sv
// ============================================================================
//  Module   : tft_underflow_mon
//  Brief    : Sticky pixel-FIFO underflow flag; a set event beats a clear.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tft_underflow_mon (
    input  logic clk,
    input  logic rst,
    input  logic i_set,
    input  logic i_clr,
    output logic o_flag
);

    logic r_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag <= 1'b0;
        end else if (i_set) begin
            r_flag <= 1'b1;
        end else if (i_clr) begin
            r_flag <= 1'b0;
        end
    end

    assign o_flag = r_flag;

endmodule

`default_nettype wire

// File: rtl/tft_frame_fetch_ctrl.sv
// ============================================================================
//  Module   : tft_frame_fetch_ctrl
//  Brief    : Burst read sequencer that streams one frame buffer into the TFT
//             pixel FIFO. Define TFT_DOUBLE_BUFFER_EN for ping-pong frames.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tft_frame_fetch_ctrl
    import tft_fetch_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 800,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned BURST_LEN  = 32,
    parameter int unsigned FIFO_DEPTH = 1024,
    parameter int unsigned ADDR_W     = 24
) (
    input  logic              Clk33M,
    input  logic              Rst,
    input  logic              Enable,
    input  logic              Frame_start,
    input  logic [ADDR_W-1:0] Base_addr,
    input  logic [10:0]       Fifo_usedw,
    input  logic              Fifo_empty,
    input  logic              Pixel_rd,
    output logic              Rd_req,
    output logic [ADDR_W-1:0] Rd_addr,
    output logic [7:0]        Rd_len,
    input  logic              Rd_ack,
    input  logic              Rd_done,
    output logic              Fifo_clr,
    output logic              Busy,
`ifdef TFT_DOUBLE_BUFFER_EN
    output logic              Buf_sel,
`endif
    output logic              Underflow
);

    localparam int unsigned c_FRAME_WORDS = frame_words(H_ACTIVE, V_ACTIVE);
    localparam int unsigned c_CNT_W       = cnt_width(c_FRAME_WORDS + 1);
    localparam int unsigned c_SPACE_LIM   = FIFO_DEPTH - BURST_LEN;

    fetch_state_t         r_state;
    fetch_state_t         w_state_nxt;
    logic [ADDR_W-1:0]    r_base;
    logic [ADDR_W-1:0]    r_cur_addr;
    logic [c_CNT_W-1:0]   r_words_left;
    logic [ADDR_W-1:0]    r_rd_addr;
    logic [7:0]           r_rd_len;
    logic                 r_pending;
    logic [ADDR_W-1:0]    w_origin;
    logic [7:0]           w_burst_len;
    logic                 w_space_ok;
    logic                 w_last_burst;
    logic                 w_enter_clear;
    logic                 w_uf_set;

    assign w_space_ok    = (32'(Fifo_usedw) <= c_SPACE_LIM);
    assign w_last_burst  = (32'(r_words_left) == 32'(r_rd_len));
    assign w_enter_clear = (w_state_nxt == CLEAR);
    assign w_uf_set      = Pixel_rd & Fifo_empty;

    always_comb begin
        w_burst_len = 8'(BURST_LEN);
        if (32'(r_words_left) < BURST_LEN) begin
            w_burst_len = 8'(r_words_left);
        end
    end

`ifdef TFT_DOUBLE_BUFFER_EN
    logic r_buf_sel;

    always_ff @(posedge Clk33M) begin
        if (Rst) begin
            r_buf_sel <= 1'b0;
        end else if (w_enter_clear) begin
            r_buf_sel <= ~r_buf_sel;
        end
    end

    // Origin is taken in CLEAR, so it already sees the toggled buffer select.
    assign w_origin = r_base + (r_buf_sel ? ADDR_W'(c_FRAME_WORDS) : '0);
    assign Buf_sel  = r_buf_sel;
`else
    assign w_origin = r_base;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (Frame_start && Enable) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                w_state_nxt = WAIT_SPACE;
            end
            WAIT_SPACE: begin
                if (Frame_start) begin
                    w_state_nxt = CLEAR;
                end else if (w_space_ok) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                // An ack in the same cycle as Frame_start keeps the burst alive.
                if (Rd_ack) begin
                    w_state_nxt = XFER;
                end else if (Frame_start) begin
                    w_state_nxt = CLEAR;
                end
            end
            XFER: begin
                if (Rd_done) begin
                    if (r_pending || Frame_start) begin
                        w_state_nxt = CLEAR;
                    end else if (w_last_burst) begin
                        w_state_nxt = DONE;
                    end else if (!Enable) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = WAIT_SPACE;
                    end
                end
            end
            DONE: begin
                if (Frame_start) begin
                    w_state_nxt = Enable ? CLEAR : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk33M) begin
        if (Rst) begin
            r_state      <= IDLE;
            r_base       <= '0;
            r_cur_addr   <= '0;
            r_words_left <= '0;
            r_rd_addr    <= '0;
            r_rd_len     <= '0;
            r_pending    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (Frame_start) begin
                r_base <= Base_addr;
            end

            if (r_state == CLEAR) begin
                r_cur_addr   <= w_origin;
                r_words_left <= c_CNT_W'(c_FRAME_WORDS);
            end else if ((r_state == XFER) && Rd_done) begin
                r_cur_addr   <= r_cur_addr + ADDR_W'(r_rd_len);
                r_words_left <= r_words_left - c_CNT_W'(r_rd_len);
            end

            if ((r_state == WAIT_SPACE) && (w_state_nxt == REQ)) begin
                r_rd_addr <= r_cur_addr;
                r_rd_len  <= w_burst_len;
            end

            if (w_enter_clear) begin
                r_pending <= 1'b0;
            end else if (Frame_start &&
                         (((r_state == XFER) && !Rd_done) ||
                          ((r_state == REQ) && Rd_ack))) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign Rd_req   = (r_state == REQ);
    assign Rd_addr  = r_rd_addr;
    assign Rd_len   = r_rd_len;
    assign Fifo_clr = (r_state == CLEAR);
    assign Busy     = (r_state == CLEAR) || (r_state == WAIT_SPACE) ||
                      (r_state == REQ)   || (r_state == XFER);

    tft_underflow_mon u_underflow_mon (
        .clk    (Clk33M),
        .rst    (Rst),
        .i_set  (w_uf_set),
        .i_clr  (Frame_start),
        .o_flag (Underflow)
    );

endmodule

`default_nettype wire
